// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: on conflict the requester not served last wins;
// otherwise data always wins and last_served is ignored.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    f_req,
  input  logic    d_req,
  input  req_id_t last_served,
  output req_id_t winner
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_served;
  assign unused_last_served = last_served;
`endif

  // Pick the winner; with a single requester that requester wins.
  always_comb begin
    winner = REQ_DATA;
    if (f_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_served == REQ_DATA) ? REQ_FETCH : REQ_DATA;
`else
      winner = REQ_DATA;
`endif
    end else if (f_req) begin
      winner = REQ_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) single-port memory arbiter.
// Fixed 3-cycle access: IDLE grant -> ISSUE strobe -> RESP capture + ack.
// Optional macro ARB_ROUND_ROBIN_EN enables round-robin on conflict.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_q, state_n;
  req_id_t           owner_q, owner_n;
  logic              op_we_q, op_we_n;
  req_id_t           last_served;
  req_id_t           winner;

  logic              f_ack_n, d_ack_n, mem_en_n, mem_we_n, busy_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, f_rdata_n, d_rdata_n;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t last_q, last_n;
  assign last_served = last_q;
`else
  assign last_served = REQ_FETCH;
`endif

  mem_arb_pick u_pick (
    .f_req       (f_req),
    .d_req       (d_req),
    .last_served (last_served),
    .winner      (winner)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    owner_n     = owner_q;
    op_we_n     = op_we_q;
    f_ack_n     = 1'b0;
    d_ack_n     = 1'b0;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    f_rdata_n   = f_rdata;
    d_rdata_n   = d_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    last_n      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          state_n  = ISSUE;
          owner_n  = winner;
          mem_en_n = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_n   = winner;
`endif
          if (winner == REQ_DATA) begin
            op_we_n     = d_we;
            mem_we_n    = d_we;
            mem_addr_n  = d_addr;
            mem_wdata_n = d_wdata;
          end else begin
            op_we_n     = 1'b0;
            mem_we_n    = 1'b0;
            mem_addr_n  = f_addr;
            mem_wdata_n = '0;
          end
        end
      end
      ISSUE: begin
        state_n = RESP;
      end
      RESP: begin
        state_n = IDLE;
        if (owner_q == REQ_DATA) begin
          d_ack_n = 1'b1;
          if (!op_we_q) begin
            d_rdata_n = mem_rdata;
          end
        end else begin
          f_ack_n   = 1'b1;
          f_rdata_n = mem_rdata;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= REQ_FETCH;
      op_we_q   <= 1'b0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= REQ_FETCH;
`endif
    end else begin
      state_q   <= state_n;
      owner_q   <= owner_n;
      op_we_q   <= op_we_n;
      f_ack     <= f_ack_n;
      d_ack     <= d_ack_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      f_rdata   <= f_rdata_n;
      d_rdata   <= d_rdata_n;
      busy      <= busy_n;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= last_n;
`endif
    end
  end

endmodule
